// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the core's single-port instruction/data memory between the fetch
// stage and the load/store stage. One request is accepted at a time over a
// valid/ready handshake. It is issued to memory as a registered one-cycle
// command. For reads the block then waits out MEM_LAT cycles before it
// returns a one-cycle response to the requester that owns the transaction.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, data has fixed priority over fetch.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   // instruction fetch requester
   input  logic                  if_req_valid,
   input  logic [ADDR_W-1:0]     if_req_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [DATA_W-1:0]     if_rsp_data,
   // load/store requester
   input  logic                  d_req_valid,
   input  logic                  d_req_we,
   input  logic [ADDR_W-1:0]     d_req_addr,
   input  logic [DATA_W-1:0]     d_req_wdata,
   input  logic [DATA_W/8-1:0]   d_req_wstrb,
   output logic                  d_req_ready,
   output logic                  d_rsp_valid,
   output logic [DATA_W-1:0]     d_rsp_data,
   // memory macro
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic [DATA_W-1:0]     mem_rdata,
   // status
   output logic                  busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WAIT,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic                own_d_q, own_d_d;     // 1 = transaction belongs to data port
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
   logic                last_d_q, last_d_d;   // 1 = data granted last, 0 = fetch
`endif

   logic                accept_win;
   logic                prefer_data;
   logic                gnt_if;
   logic                gnt_d;
   logic                hs;

   // Grant: new requests are taken only in IDLE or RESP, never under reset.
   always_comb begin
      accept_win = !reset && ((state_q == IDLE) || (state_q == RESP));
`ifdef ARB_ROUND_ROBIN_EN
      prefer_data = !last_d_q;
`else
      prefer_data = 1'b1;
`endif
      gnt_d  = accept_win && d_req_valid  && (!if_req_valid || prefer_data);
      gnt_if = accept_win && if_req_valid && !(d_req_valid && prefer_data);
      hs     = gnt_d || gnt_if;
   end

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         own_d_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         own_d_q  <= own_d_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= last_d_d;
`endif
      end
   end

   // Next state, latency counter and payload capture.
   always_comb begin
      state_d  = state_q;
      own_d_d  = own_d_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d = last_d_q;
`endif
      case (state_q)
         IDLE, RESP: begin
            state_d = hs ? CMD : IDLE;
         end
         CMD: begin
            if (we_q) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
               cnt_d   = CNT_W'(MEM_LAT);
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               rdata_d = mem_rdata;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Fetches and reads carry no write data or strobes. The response word
      // is cleared here so that a write answers with 0.
      if (hs) begin
         own_d_d = gnt_d;
         we_d    = gnt_d && d_req_we;
         addr_d  = gnt_d ? d_req_addr : if_req_addr;
         wdata_d = (gnt_d && d_req_we) ? d_req_wdata : '0;
         wstrb_d = (gnt_d && d_req_we) ? d_req_wstrb : '0;
         rdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_d = gnt_d;
`endif
      end
   end

   assign if_req_ready = gnt_if;
   assign d_req_ready  = gnt_d;

   // Memory command and response outputs. These are forced to 0 while reset is held.
   always_comb begin
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wstrb    = '0;
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      d_rsp_valid  = 1'b0;
      d_rsp_data   = '0;
      busy         = 1'b0;
      if (!reset) begin
         busy = (state_q != IDLE);
         if (state_q == CMD) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wstrb = wstrb_q;
         end
         if (state_q == RESP) begin
            if (own_d_q) begin
               d_rsp_valid = 1'b1;
               d_rsp_data  = rdata_q;
            end else begin
               if_rsp_valid = 1'b1;
               if_rsp_data  = rdata_q;
            end
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the CPU's single-port instruction/data memory between the instruction-fetch stage and the load/store stage. It accepts one request at a time from either requester over a valid/ready handshake and issues it to the memory as a registered command. It waits out the fixed memory read latency, then returns a one-cycle response pulse to the requester that issued the request. The block sits between the pipeline stages of the core and the memory macro inside the system top level.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- MEM_LAT, 1, memory read latency in cycles, legal range 1..4
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  DATA_W  fetched word
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  write data
- d_req_wstrb  in  DATA_W/8  byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  data response pulse (reads and writes)
- d_rsp_data  out  DATA_W  read data; 0 for writes
- mem_en, mem_we  out  1  memory command strobe and write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wstrb  out  DATA_W/8
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state is not IDLE

## Operation
- **States:** IDLE, CMD, WAIT, RESP.
- **Handshake:** a transfer occurs on `x_req_valid && x_req_ready`.
  - `x_req_ready` is combinational and is high only in IDLE or RESP, and only for the granted requester. At most one ready is high per cycle.
  - Requesters hold valid and payload stable until ready. The payload is registered at the handshake.
- **IDLE/RESP → CMD:** on a handshake, drive mem_en=1 for exactly one cycle with the registered payload.
  - A fetch always drives mem_we=0 and mem_wstrb=0.
  - A read drives mem_wstrb=0.
- **CMD:**
  - For a write, go to RESP.
  - For a read, go to WAIT.
- **WAIT:** lasts exactly MEM_LAT cycles, driven by a down-counter of width clog2(MEM_LAT+1). mem_rdata is captured on the last WAIT edge. Then go to RESP.
- **RESP:**
  - Pulse rsp_valid for one cycle on the owning requester only, with rsp_data equal to the captured word (0 for a write).
  - A new handshake in RESP goes to CMD. Otherwise go to IDLE.
- **Arbitration:** applies in IDLE/RESP when both valids are high; see Configuration. A single valid is always granted.
- **Idle outputs:** when no transaction is in flight, all mem_* outputs are 0.

## Timing
- **Reset:** every output is 0 in the reset cycle and the cycle after, except that ready may rise combinationally in the first non-reset IDLE cycle.
  - State goes to IDLE and the latency counter is cleared.
  - Any in-flight transaction is dropped and no response is ever emitted for it.
- **Latencies**, for a handshake in cycle T:
  - mem_en is high in cycle T+1.
  - A read response is in cycle T+MEM_LAT+2.
  - A write response is in cycle T+2.
- **Throughput:** one read per MEM_LAT+2 cycles and one write per 2 cycles when requests arrive back to back, because acceptance in RESP overlaps the response.
- **Simultaneous response and accept:** a response pulse and a new acceptance in the same RESP cycle are legal, including for the same requester.
- **Reset priority:** reset asserted in the same cycle as a handshake wins; the request is not accepted.

## Configuration
- **ARB_ROUND_ROBIN_EN undefined:** fixed priority; data always wins contention and fetch may starve.
- **ARB_ROUND_ROBIN_EN defined:** round-robin between the two requesters.
  - A last_grant register is updated on every handshake and resets to "fetch".
  - On contention, the requester not granted last wins, so the first contention after reset goes to data.

## Test plan
- MEM_LAT=1, fetch 0x100 accepted at T, mem_rdata=0x00500093 → mem_en/addr=0x100/we=0 at T+1; if_rsp_valid with data 0x00500093 at T+3 only; d_rsp_valid stays 0.
- Data write 0x200, wdata 0xDEADBEEF, wstrb 0xF at T → mem_we=1 with wstrb 0xF at T+1; d_rsp_valid with data 0 at T+2.
- Both valids held high for 4 transactions, macro undefined → grants D,D,D,D; if_req_ready never high.
- Same stimulus with ARB_ROUND_ROBIN_EN defined → grants D,F,D,F; each response goes to the correct port.
- MEM_LAT=3, back-to-back reads 0x10 then 0x14 → first response at T+5; second request accepted at T+5 with its response at T+10.
- reset asserted during WAIT → no rsp_valid afterwards and all outputs 0; a fetch issued after reset deasserts completes with normal latency.
